lcd_ctrl: RTL and testbench

//  Write-only HD44780-compatible character-LCD driver (16x2, 8-bit bus) for the parking-lot display.
//  - After power-up it initialises the panel, then refreshes two lines forever.
//  - Line 1: "CAR: NN" (free spaces, from car). Line 2: "TIME: NN" (time_cnt).
//  - Bus timing is paced by a slow strobe, scan_clk, sampled in the clk domain.

---
 rtl/lcd_ctrl_pkg.sv | 36 +++
 rtl/lcd_ctrl_if.sv | 12 +
 rtl/lcd_bin2dec.sv | 22 ++
 rtl/lcd_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the HD44780 parking-display driver: state enum,
// LCD command bytes, ASCII glyphs and the digit-to-character helper.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    REFRESH = 2'd2
  } lcd_state_t;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_A     = 8'h41;
  localparam logic [7:0] ASC_C     = 8'h43;
  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_I     = 8'h49;
  localparam logic [7:0] ASC_M     = 8'h4D;
  localparam logic [7:0] ASC_R     = 8'h52;
  localparam logic [7:0] ASC_T     = 8'h54;

  localparam int INIT_CMDS = 4;
  localparam int FRAME_LEN = 17;

  // A zero tens digit may be shown as a blank instead of '0'.
  function automatic logic [7:0] digit_char(input logic [3:0] d, input logic blank_zero);
    if (blank_zero && (d == 4'd0)) return ASC_SPACE;
    return ASC_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Write-only HD44780 parallel bus between the controller and the panel.
interface lcd_ctrl_if;
  // The panel latches {RS, data_bus} on the falling edge of EN; RS and
  // data_bus are stable for the whole EN-high window. RW is always 0.
  logic       RW;
  logic       EN;
  logic       RS;
  logic [7:0] data_bus;

  modport master (output RW, EN, RS, data_bus);
  modport slave  (input  RW, EN, RS, data_bus);
endinterface

// File: rtl/lcd_bin2dec.sv
// Combinational 6-bit binary to two BCD digits by range comparison.
module lcd_bin2dec (
  input  logic [5:0] i_bin,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [5:0] w_rem;

  always_comb begin
    o_tens = 4'd0;
    w_rem  = i_bin;
    if      (i_bin >= 6'd60) begin o_tens = 4'd6; w_rem = i_bin - 6'd60; end
    else if (i_bin >= 6'd50) begin o_tens = 4'd5; w_rem = i_bin - 6'd50; end
    else if (i_bin >= 6'd40) begin o_tens = 4'd4; w_rem = i_bin - 6'd40; end
    else if (i_bin >= 6'd30) begin o_tens = 4'd3; w_rem = i_bin - 6'd30; end
    else if (i_bin >= 6'd20) begin o_tens = 4'd2; w_rem = i_bin - 6'd20; end
    else if (i_bin >= 6'd10) begin o_tens = 4'd1; w_rem = i_bin - 6'd10; end
    o_ones = w_rem[3:0];
  end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 16x2 driver: init sequence then endless "CAR: NN" / "TIME: NN" refresh.
// Optional LCD_LEADING_BLANK_EN shows a zero tens digit as a blank.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int         CLR_WAIT   = 2,   // must be >= 1
  parameter logic [7:0] LINE1_ADDR = 8'h80,
  parameter logic [7:0] LINE2_ADDR = 8'hC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_clk,
  input  logic        power,
  input  logic [3:0]  car,
  input  logic [5:0]  time_cnt,
  lcd_ctrl_if.master  lcd,
  output lcd_state_t  o_dbg_state
);

`ifdef LCD_LEADING_BLANK_EN
  localparam logic LEAD_BLANK = 1'b1;
`else
  localparam logic LEAD_BLANK = 1'b0;
`endif

  localparam logic [4:0] WAIT_LAST = 5'(INIT_CMDS + CLR_WAIT - 1);
  localparam logic [4:0] FRAME_END = 5'(FRAME_LEN - 1);

  lcd_state_t r_state, w_state_nxt;
  logic [4:0] r_idx, w_idx_nxt;
  logic       r_phase, w_phase_nxt;   // 0: next tick is SETUP, 1: next tick is STROBE
  logic       r_en, w_en_nxt;
  logic       r_rs, w_rs_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic [2:0] r_sync;
  logic [3:0] r_car;
  logic [5:0] r_time;
  logic       w_tick;
  logic       w_snap;
  logic [3:0] w_c_tens, w_c_ones, w_t_tens, w_t_ones;
  logic [8:0] w_frame_byte;
  logic [7:0] w_init_byte;

  // Two synchroniser flops, then a third for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= 3'b000;
    else      r_sync <= {r_sync[1:0], scan_clk};
  end
  assign w_tick = r_sync[1] & ~r_sync[2];

  lcd_bin2dec u_car_dec  (.i_bin({2'b00, r_car}), .o_tens(w_c_tens), .o_ones(w_c_ones));
  lcd_bin2dec u_time_dec (.i_bin(r_time),         .o_tens(w_t_tens), .o_ones(w_t_ones));

  always_comb begin
    w_init_byte = CMD_FUNC_8B2L;
    case (r_idx[1:0])
      2'd0:    w_init_byte = CMD_FUNC_8B2L;
      2'd1:    w_init_byte = CMD_DISP_ON;
      2'd2:    w_init_byte = CMD_ENTRY_INC;
      default: w_init_byte = CMD_CLEAR;
    endcase
  end

  always_comb begin
    w_frame_byte = 9'h000;
    case (r_idx)
      5'd0:    w_frame_byte = {1'b0, LINE1_ADDR};
      5'd1:    w_frame_byte = {1'b1, ASC_C};
      5'd2:    w_frame_byte = {1'b1, ASC_A};
      5'd3:    w_frame_byte = {1'b1, ASC_R};
      5'd4:    w_frame_byte = {1'b1, ASC_COLON};
      5'd5:    w_frame_byte = {1'b1, ASC_SPACE};
      5'd6:    w_frame_byte = {1'b1, digit_char(w_c_tens, LEAD_BLANK)};
      5'd7:    w_frame_byte = {1'b1, digit_char(w_c_ones, 1'b0)};
      5'd8:    w_frame_byte = {1'b0, LINE2_ADDR};
      5'd9:    w_frame_byte = {1'b1, ASC_T};
      5'd10:   w_frame_byte = {1'b1, ASC_I};
      5'd11:   w_frame_byte = {1'b1, ASC_M};
      5'd12:   w_frame_byte = {1'b1, ASC_E};
      5'd13:   w_frame_byte = {1'b1, ASC_COLON};
      5'd14:   w_frame_byte = {1'b1, ASC_SPACE};
      5'd15:   w_frame_byte = {1'b1, digit_char(w_t_tens, LEAD_BLANK)};
      5'd16:   w_frame_byte = {1'b1, digit_char(w_t_ones, 1'b0)};
      default: w_frame_byte = 9'h000;
    endcase
  end

  // State register together with the sequencing and bus registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= 5'd0;
      r_phase <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_phase <= w_phase_nxt;
      r_en    <= w_en_nxt;
      r_rs    <= w_rs_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Inputs are frozen at the LINE1_ADDR setup so both lines of a frame agree.
  assign w_snap = power && w_tick && (r_state == REFRESH) && !r_phase && (r_idx == 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_car  <= 4'd0;
      r_time <= 6'd0;
    end else if (w_snap) begin
      r_car  <= car;
      r_time <= time_cnt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_phase_nxt = r_phase;
    if (!power) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = 5'd0;
      w_phase_nxt = 1'b0;
    end else if (w_tick) begin
      case (r_state)
        IDLE: begin
          w_state_nxt = INIT;
          w_idx_nxt   = 5'd0;
          w_phase_nxt = 1'b0;
        end
        INIT: begin
          if (r_idx < 5'(INIT_CMDS)) begin
            w_phase_nxt = ~r_phase;
            if (r_phase) w_idx_nxt = r_idx + 5'd1;
          end else if (r_idx == WAIT_LAST) begin
            w_state_nxt = REFRESH;
            w_idx_nxt   = 5'd0;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
        REFRESH: begin
          w_phase_nxt = ~r_phase;
          if (r_phase) w_idx_nxt = (r_idx == FRAME_END) ? 5'd0 : r_idx + 5'd1;
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 5'd0;
          w_phase_nxt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_en_nxt   = r_en;
    w_rs_nxt   = r_rs;
    w_data_nxt = r_data;
    if (!power) begin
      w_en_nxt = 1'b0;
    end else if (w_tick) begin
      case (r_state)
        INIT: begin
          if ((r_idx < 5'(INIT_CMDS)) && !r_phase) begin
            w_en_nxt   = 1'b0;
            w_rs_nxt   = 1'b0;
            w_data_nxt = w_init_byte;
          end else if (r_idx < 5'(INIT_CMDS)) begin
            w_en_nxt = 1'b1;
          end else begin
            w_en_nxt = 1'b0;
          end
        end
        REFRESH: begin
          if (!r_phase) begin
            w_en_nxt   = 1'b0;
            w_rs_nxt   = w_frame_byte[8];
            w_data_nxt = w_frame_byte[7:0];
          end else begin
            w_en_nxt = 1'b1;
          end
        end
        default: w_en_nxt = 1'b0;
      endcase
    end
  end

  assign lcd.RW       = 1'b0;
  assign lcd.EN       = r_en;
  assign lcd.RS       = r_rs;
  assign lcd.data_bus = r_data;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: captures every EN strobe as {RS, data_bus} and compares
// against frames built from the display text.
module tb_lcd_ctrl;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_clk = 1'b0;
  logic       power = 1'b0;
  logic [3:0] car = 4'd0;
  logic [5:0] time_cnt = 6'd0;
  lcd_state_t dbg_state;

  lcd_ctrl_if lcd ();

  lcd_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .scan_clk   (scan_clk),
    .power      (power),
    .car        (car),
    .time_cnt   (time_cnt),
    .lcd        (lcd),
    .o_dbg_state(dbg_state)
  );

  // Clock / pacing strobe
  always #5  clk = ~clk;
  always #20 scan_clk = ~scan_clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [8:0] cap_q[$];
  logic [8:0] exp_q[$];
  logic       prev_en = 1'b0;

  // Capture on EN rising: the byte is then stable until the latching fall.
  always @(negedge clk) begin
    if (rst && lcd.EN && !prev_en) cap_q.push_back({lcd.RS, lcd.data_bus});
    prev_en = rst ? lcd.EN : 1'b0;
  end

  function automatic logic [7:0] ref_digit(input int v, input bit tens);
    int d;
    d = tens ? (v / 10) : (v % 10);
`ifdef LCD_LEADING_BLANK_EN
    if (tens && d == 0) return 8'h20;
`endif
    return 8'(8'h30 + d);
  endfunction

  task automatic push_frame(input int c, input int t);
    string s1;
    string s2;
    s1 = "CAR: ";
    s2 = "TIME: ";
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < s1.len(); i++) exp_q.push_back({1'b1, s1[i]});
    exp_q.push_back({1'b1, ref_digit(c, 1'b1)});
    exp_q.push_back({1'b1, ref_digit(c, 1'b0)});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < s2.len(); i++) exp_q.push_back({1'b1, s2[i]});
    exp_q.push_back({1'b1, ref_digit(t, 1'b1)});
    exp_q.push_back({1'b1, ref_digit(t, 1'b0)});
  endtask

  task automatic get_byte(output logic [8:0] b, output bit ok);
    int waited;
    waited = 0;
    while (cap_q.size() == 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    ok = (cap_q.size() != 0);
    b  = ok ? cap_q.pop_front() : 9'h1FF;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      power = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_total++;
      if ({lcd.EN, lcd.RS, lcd.RW} !== 3'b000 || lcd.data_bus !== 8'h00 || dbg_state !== IDLE)
        $display("FAIL reset: EN=%b RS=%b RW=%b data=%h state=%0d, required all zero and IDLE",
                 lcd.EN, lcd.RS, lcd.RW, lcd.data_bus, dbg_state);
      else n_pass++;
    end
  endtask

  task automatic test_init();
    logic [8:0] got;
    logic [8:0] exp;
    bit ok;
    exp_q = {};
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006);
    exp_q.push_back(9'h001);
    for (int i = 0; i < 4; i++) begin
      get_byte(got, ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok || got !== exp)
        $display("FAIL init[%0d]: got %h (captured=%0b), required %h", i, got, ok, exp);
      else n_pass++;
    end
  endtask

  task automatic test_frame(input int c, input int t);
    logic [8:0] got;
    logic [8:0] exp;
    bit ok;
    exp_q = {};
    push_frame(c, t);
    for (int i = 0; i < FRAME_LEN; i++) begin
      get_byte(got, ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok || got !== exp)
        $display("FAIL frame c=%0d t=%0d byte %0d: got %h, required %h", c, t, i, got, exp);
      else n_pass++;
    end
  endtask

  // Changes inputs after k bytes of a frame: that frame keeps old values.
  task automatic test_snapshot(input int c_old, input int t_old, input int k,
                               input int c_new, input int t_new);
    logic [8:0] got;
    logic [8:0] exp;
    bit ok;
    exp_q = {};
    push_frame(c_old, t_old);
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i == k) begin
        car      = 4'(c_new);
        time_cnt = 6'(t_new);
      end
      get_byte(got, ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok || got !== exp)
        $display("FAIL snapshot old frame byte %0d: got %h, required %h", i, got, exp);
      else n_pass++;
    end
    test_frame(c_new, t_new);
  endtask

  task automatic test_power(input int c, input int t);
    logic [8:0] got;
    bit ok;
    int k;
    k = $urandom_range(1, 12);
    for (int i = 0; i < k; i++) get_byte(got, ok);
    repeat ($urandom_range(0, 6)) @(negedge clk);
    power = 1'b0;
    @(negedge clk);
    n_total++;
    if (lcd.EN !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL power_off: EN=%b state=%0d, required EN=0 IDLE", lcd.EN, dbg_state);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_total++;
      if (lcd.EN !== 1'b0) $display("FAIL power_off_hold: EN=%b, required 0", lcd.EN);
      else n_pass++;
    end
    cap_q    = {};
    car      = 4'(c);
    time_cnt = 6'(t);
    power    = 1'b1;
    test_init();
    test_frame(c, t);
  endtask

  initial begin
    int c_cur;
    int t_cur;
    int c_nx;
    int t_nx;
    test_reset();
    car      = 4'd2;
    time_cnt = 6'd2;
    @(negedge clk);
    rst   = 1'b1;
    power = 1'b1;
    test_init();
    test_frame(2, 2);
    test_snapshot(2, 2, 4, 2, 63);
    c_cur = 2;
    t_cur = 63;
    for (int r = 0; r < 5; r++) begin
      c_nx = (r == 0) ? 15 : int'($urandom_range(0, 15));
      t_nx = (r == 0) ? 0  : int'($urandom_range(0, 63));
      test_snapshot(c_cur, t_cur, $urandom_range(1, 16), c_nx, t_nx);
      c_cur = c_nx;
      t_cur = t_nx;
    end
    test_power(15, 9);
    test_power($urandom_range(0, 15), $urandom_range(10, 63));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
